mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/mem_lane.sv | 75 +++++++
 rtl/mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: RISC-V load/store size codes (funct3).
package mem_ctrl_pkg;

  localparam logic [2:0] LB3  = 3'b000;
  localparam logic [2:0] LH3  = 3'b001;
  localparam logic [2:0] LW3  = 3'b010;
  localparam logic [2:0] LBU3 = 3'b100;
  localparam logic [2:0] LHU3 = 3'b101;
  localparam logic [2:0] SB3  = 3'b000;
  localparam logic [2:0] SH3  = 3'b001;
  localparam logic [2:0] SW3  = 3'b010;

endpackage

// File: rtl/mem_lane.sv
// Combinational lane logic: legality checks, store byte-enable/data positioning,
// and load byte/halfword extraction with sign or zero extension.
module mem_lane
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 20
) (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] ram_rdata_i,
  output logic        err_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  // Highest legal byte address; 33 bits so RAM_ADDR_BITS up to 32 still fits.
  localparam logic [32:0] Limit = (33'd1 << RAM_ADDR_BITS) - 33'd4;

  logic [1:0]  off;
  logic [31:0] shifted;
  logic        oor;
  logic        bad_code;
  logic        misalign;

  always_comb begin
    off      = addr_i[1:0];
    shifted  = ram_rdata_i >> {off, 3'b000};
    oor      = {1'b0, addr_i} > Limit;
    bad_code = 1'b0;
    misalign = 1'b0;
    case (funct3_i)
      LB3:     bad_code = 1'b0;
      LH3:     misalign = off[0];
      LW3:     misalign = (off != 2'b00);
      LBU3:    bad_code = we_i;
      LHU3:    begin
        bad_code = we_i;
        misalign = off[0];
      end
      default: bad_code = 1'b1;
    endcase
    err_o = bad_code | misalign | oor;

    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    if (!err_o) begin
      case (funct3_i[1:0])
        2'b00:   be_o = 4'b0001 << off;
        2'b01:   be_o = 4'b0011 << off;
        default: be_o = 4'b1111;
      endcase
      if (we_i) begin
        // Narrow store data is replicated; byte enables pick the live lane.
        case (funct3_i)
          SB3:     wdata_o = {4{wdata_i[7:0]}};
          SH3:     wdata_o = {2{wdata_i[15:0]}};
          default: wdata_o = wdata_i;
        endcase
      end else begin
        case (funct3_i)
          LB3:     rdata_o = {{24{shifted[7]}}, shifted[7:0]};
          LH3:     rdata_o = {{16{shifted[15]}}, shifted[15:0]};
          LBU3:    rdata_o = {24'd0, shifted[7:0]};
          LHU3:    rdata_o = {16'd0, shifted[15:0]};
          default: rdata_o = ram_rdata_i;
        endcase
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Two-port (fetch/data) memory controller: round-robin arbitration in IDLE,
// one RAM access cycle, then a one-cycle ack. Sustained rate one access per 3 cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] ram_addr,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q;
  logic        last_d_q;
  logic        gnt_d_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;

  logic        if_ack_q, d_ack_q, if_err_q, d_err_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic [31:0] ram_addr_q, ram_wdata_q;
  logic        ram_we_q;
  logic [3:0]  ram_be_q;

  logic        pick_d;
  logic [31:0] in_addr, in_wdata;
  logic        in_we;
  logic [2:0]  in_f3;
  logic        lane_we;
  logic [2:0]  lane_f3;
  logic [31:0] lane_addr, lane_wdata_in;
  logic        lane_err;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  // A fetch is checked exactly like an LW load.
  always_comb begin
    pick_d   = d_req & (~if_req | ~last_d_q);
    in_addr  = pick_d ? d_addr : if_addr;
    in_we    = pick_d & d_we;
    in_f3    = pick_d ? d_funct3 : LW3;
    in_wdata = pick_d ? d_wdata : 32'd0;
    if (state_q == StIdle) begin
      lane_we       = in_we;
      lane_f3       = in_f3;
      lane_addr     = in_addr;
      lane_wdata_in = in_wdata;
    end else begin
      lane_we       = we_q;
      lane_f3       = f3_q;
      lane_addr     = addr_q;
      lane_wdata_in = wdata_q;
    end
  end

  mem_lane #(
    .RAM_ADDR_BITS (RAM_ADDR_BITS)
  ) u_lane (
    .we_i        (lane_we),
    .funct3_i    (lane_f3),
    .addr_i      (lane_addr),
    .wdata_i     (lane_wdata_in),
    .ram_rdata_i (ram_rdata),
    .err_o       (lane_err),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_d_q    <= 1'b0;
      gnt_d_q     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      wdata_q     <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_wdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (if_req | d_req) begin
            state_q     <= StAccess;
            gnt_d_q     <= pick_d;
            last_d_q    <= pick_d;
            addr_q      <= in_addr;
            we_q        <= in_we;
            f3_q        <= in_f3;
            wdata_q     <= in_wdata;
            ram_addr_q  <= {in_addr[31:2], 2'b00};
            ram_we_q    <= in_we & ~lane_err;
            ram_be_q    <= lane_be;
            ram_wdata_q <= lane_wdata;
          end
        end
        StAccess: begin
          state_q     <= StResp;
          ram_addr_q  <= '0;
          ram_we_q    <= 1'b0;
          ram_be_q    <= '0;
          ram_wdata_q <= '0;
          if (gnt_d_q) begin
            d_ack_q   <= 1'b1;
            d_err_q   <= lane_err;
            d_rdata_q <= lane_rdata;
          end else begin
            if_ack_q   <= 1'b1;
            if_err_q   <= lane_err;
            if_rdata_q <= lane_rdata;
          end
        end
        default: begin
          state_q    <= StIdle;
          if_ack_q   <= 1'b0;
          d_ack_q    <= 1'b0;
          if_err_q   <= 1'b0;
          d_err_q    <= 1'b0;
          if_rdata_q <= '0;
          d_rdata_q  <= '0;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_be    = ram_be_q;
  assign ram_wdata = ram_wdata_q;
  // Reset falling during ACCESS must suppress the write at the closing edge.
  assign ram_we    = ram_we_q & reset;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural RAM plus a queue of expected responses.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic [3:0]  ram_be;

  always #5 clk = ~clk;

  mem_ctrl #(
    .RAM_ADDR_BITS (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_funct3  (d_funct3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_be    (ram_be),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Behavioural RAM, 4 KiB window (addresses alias modulo 4 KiB).
  logic [31:0] mem [1024];
  logic        pl_en, pl_clr;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;
  int          we_cnt = 0;

  assign ram_rdata = mem[ram_addr[11:2]];

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (ram_we) begin
      we_cnt <= we_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;

  int          lat;
  logic        got, obs_err, obs_other;
  logic [31:0] obs_rd;
  logic        acc_we;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata, acc_addr;

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    got = 1'b0; lat = 0; obs_rd = '0; obs_err = 1'b0; obs_other = 1'b0;
    acc_we = 1'b0; acc_be = '0; acc_wdata = '0; acc_addr = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        acc_we = ram_we; acc_be = ram_be; acc_wdata = ram_wdata; acc_addr = ram_addr;
        // Scramble inputs: the access must use the values registered at grant.
        d_addr = ~addr; d_wdata = ~wdata; d_funct3 = 3'b011; d_we = ~we;
      end
      if (d_ack) begin
        got = 1'b1; obs_rd = d_rdata; obs_err = d_err; obs_other = if_ack;
      end
    end
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic f_access(input logic [31:0] addr);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    got = 1'b0; lat = 0; obs_rd = '0; obs_err = 1'b0; obs_other = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) if_addr = ~addr;
      if (if_ack) begin
        got = 1'b1; obs_rd = if_rdata; obs_err = if_err; obs_other = d_ack;
      end
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
    pl_en = 1'b0; pl_clr = 1'b1; pl_idx = '0; pl_val = '0;
    repeat (3) @(negedge clk);
    pl_clr = 1'b0;
    n_checks++;
    if ({if_ack, d_ack, if_err, d_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {if_ack, d_ack, if_err, d_err});
    end
    n_checks++;
    if ({if_rdata, d_rdata} !== 64'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h want 0", if_rdata, d_rdata);
    end
    n_checks++;
    if ({ram_addr, ram_wdata, ram_be, ram_we} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_ram: got addr %h wdata %h be %b we %b want 0", ram_addr, ram_wdata,
               ram_be, ram_we);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int acks;
    preload(10'h040, 32'h8899AABB);
    preload(10'h080, 32'h11223344);
    reset = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = LW3; d_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h100;
    sb.push_back('{1'b1, 32'h11223344, 1'b0, 3});
    sb.push_back('{1'b0, 32'h8899AABB, 1'b0, 6});
    sb.push_back('{1'b1, 32'h11223344, 1'b0, 9});
    sb.push_back('{1'b0, 32'h8899AABB, 1'b0, 12});
    @(negedge clk);
    reset = 1'b1;
    n = 1;
    acks = 0;
    while (acks < 4 && n < 30) begin
      @(negedge clk);
      n++;
      if (d_ack || if_ack) begin
        acks++;
        e = sb.pop_front();
        n_checks++;
        if ({d_ack, if_ack} !== {e.is_d, ~e.is_d}) begin
          n_fail++; $display("FAIL rr_grant%0d: got d/i ack %b%b want %b", acks, d_ack, if_ack,
                             {e.is_d, ~e.is_d});
        end
        n_checks++;
        if (n != e.cyc) begin
          n_fail++; $display("FAIL rr_cycle%0d: got cycle %0d want %0d", acks, n, e.cyc);
        end
        n_checks++;
        if ((d_ack ? d_rdata : if_rdata) !== e.rdata) begin
          n_fail++; $display("FAIL rr_rdata%0d: got %h want %h", acks,
                             d_ack ? d_rdata : if_rdata, e.rdata);
        end
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL rr_timeout: got %0d acks want 4", acks);
      sb.delete();
    end
  endtask

  task automatic test_load_word;
    sb.push_back('{1'b1, 32'h8899AABB, 1'b0, 2});
    d_access(1'b0, LW3, 32'h100, 32'h0);
    e = sb.pop_front();
    n_checks++;
    if (!got || lat != e.cyc) begin
      n_fail++; $display("FAIL lw_latency: got %0d (ack %b) want %0d", lat, got, e.cyc);
    end
    n_checks++;
    if ({obs_err, obs_rd} !== {e.err, e.rdata}) begin
      n_fail++; $display("FAIL lw_data: got err %b rdata %h want err %b rdata %h", obs_err,
                         obs_rd, e.err, e.rdata);
    end
    n_checks++;
    if ({acc_addr, acc_we, obs_other} !== {32'h100, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL lw_ram: got addr %h we %b if_ack %b want 100 0 0", acc_addr,
                         acc_we, obs_other);
    end
  endtask

  task automatic test_store_byte;
    int w0;
    w0 = we_cnt;
    d_access(1'b1, SB3, 32'h203, 32'h000000EE);
    n_checks++;
    if ({got, acc_we, acc_be, obs_err} !== {1'b1, 1'b1, 4'b1000, 1'b0}) begin
      n_fail++; $display("FAIL sb_strobe: got ack %b we %b be %b err %b want 1 1 1000 0", got,
                         acc_we, acc_be, obs_err);
    end
    n_checks++;
    if (acc_wdata !== 32'hEEEEEEEE || acc_addr !== 32'h200) begin
      n_fail++; $display("FAIL sb_wdata: got %h @%h want eeeeeeee @200", acc_wdata, acc_addr);
    end
    n_checks++;
    if (we_cnt - w0 != 1) begin
      n_fail++; $display("FAIL sb_we_count: got %0d want 1", we_cnt - w0);
    end
    sb.push_back('{1'b1, 32'h000000EE, 1'b0, 2});
    sb.push_back('{1'b1, 32'hFFFFFFEE, 1'b0, 2});
    sb.push_back('{1'b1, 32'hEE223344, 1'b0, 2});
    for (int k = 0; k < 3; k++) begin
      d_access(1'b0, (k == 0) ? LBU3 : (k == 1) ? LB3 : LW3, (k == 2) ? 32'h200 : 32'h203, 0);
      e = sb.pop_front();
      n_checks++;
      if ({got, obs_err, obs_rd} !== {1'b1, e.err, e.rdata}) begin
        n_fail++; $display("FAIL sb_readback%0d: got ack %b err %b rdata %h want %h", k, got,
                           obs_err, obs_rd, e.rdata);
      end
    end
  endtask

  task automatic test_store_half;
    d_access(1'b1, SH3, 32'h206, 32'hABCD8001);
    n_checks++;
    if ({acc_we, acc_be, acc_wdata} !== {1'b1, 4'b1100, 32'h80018001}) begin
      n_fail++; $display("FAIL sh_strobe: got we %b be %b wdata %h want 1 1100 80018001",
                         acc_we, acc_be, acc_wdata);
    end
    sb.push_back('{1'b1, 32'hFFFF8001, 1'b0, 2});
    sb.push_back('{1'b1, 32'h00008001, 1'b0, 2});
    for (int k = 0; k < 2; k++) begin
      d_access(1'b0, (k == 0) ? LH3 : LHU3, 32'h206, 0);
      e = sb.pop_front();
      n_checks++;
      if ({got, obs_err, obs_rd} !== {1'b1, e.err, e.rdata}) begin
        n_fail++; $display("FAIL sh_readback%0d: got ack %b err %b rdata %h want %h", k, got,
                           obs_err, obs_rd, e.rdata);
      end
    end
  endtask

  task automatic test_errors;
    logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [5] = '{LH3, SW3, 3'b011, 3'b100, LB3};
    logic [31:0] ads [5] = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h000FFFFD};
    int w0;
    w0 = we_cnt;
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{1'b1, 32'h0, 1'b1, 2});
      d_access(wes[k], f3s[k], ads[k], 32'h12345678);
      e = sb.pop_front();
      n_checks++;
      if ({got, obs_err, obs_rd, acc_we, acc_be} !== {1'b1, e.err, e.rdata, 1'b0, 4'b0}) begin
        n_fail++;
        $display("FAIL err_case%0d: got ack %b err %b rdata %h we %b be %b want 1 1 0 0 0", k,
                 got, obs_err, obs_rd, acc_we, acc_be);
      end
    end
    n_checks++;
    if (we_cnt != w0) begin
      n_fail++; $display("FAIL err_no_write: got %0d writes want 0", we_cnt - w0);
    end
    // Highest legal word address is still accepted.
    preload(10'h3FF, 32'h000000A5);
    d_access(1'b0, LBU3, 32'h000FFFFC, 0);
    n_checks++;
    if ({got, obs_err, obs_rd} !== {1'b1, 1'b0, 32'h000000A5}) begin
      n_fail++; $display("FAIL top_addr: got ack %b err %b rdata %h want 1 0 000000a5", got,
                         obs_err, obs_rd);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] ads [3] = '{32'h100, 32'h102, 32'h00100000};
    sb.push_back('{1'b0, 32'h8899AABB, 1'b0, 2});
    sb.push_back('{1'b0, 32'h0, 1'b1, 2});
    sb.push_back('{1'b0, 32'h0, 1'b1, 2});
    for (int k = 0; k < 3; k++) begin
      f_access(ads[k]);
      e = sb.pop_front();
      n_checks++;
      if ({got, obs_other, obs_err, obs_rd} !== {1'b1, 1'b0, e.err, e.rdata} || lat != e.cyc)
      begin
        n_fail++;
        $display("FAIL fetch%0d: got ack %b d_ack %b err %b rdata %h lat %0d want err %b %h",
                 k, got, obs_other, obs_err, obs_rd, lat, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_reset_abort;
    int w0;
    logic seen_ack;
    preload(10'h004, 32'h55AA55AA);
    w0 = we_cnt;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_funct3 = SW3; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b1 || ram_addr !== 32'h10) begin
      n_fail++; $display("FAIL abort_access: got we %b addr %h want 1 10", ram_we, ram_addr);
    end
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({if_ack, d_ack, if_err, d_err, ram_we, ram_be} !== 9'd0 ||
        {if_rdata, d_rdata, ram_addr, ram_wdata} !== 128'd0) begin
      n_fail++; $display("FAIL abort_outputs: got acks %b%b we %b be %b want all 0", if_ack,
                         d_ack, ram_we, ram_be);
    end
    reset = 1'b1;
    seen_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (d_ack || if_ack) seen_ack = 1'b1;
    end
    n_checks++;
    if (seen_ack || we_cnt != w0 || mem[4] !== 32'h55AA55AA) begin
      n_fail++; $display("FAIL abort_no_write: got ack %b writes %0d word %h want 0 0 55aa55aa",
                         seen_ack, we_cnt - w0, mem[4]);
    end
    sb.push_back('{1'b1, 32'h55AA55AA, 1'b0, 2});
    d_access(1'b0, LW3, 32'h10, 0);
    e = sb.pop_front();
    n_checks++;
    if ({got, obs_err, obs_rd} !== {1'b1, e.err, e.rdata}) begin
      n_fail++; $display("FAIL abort_recover: got ack %b err %b rdata %h want %h", got, obs_err,
                         obs_rd, e.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_word();
    test_store_byte();
    test_store_half();
    test_errors();
    test_fetch();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
